// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and opcode decode shared by the SPI flash responder
package spi_flash_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_RDID   = 3'd4;
  localparam logic [2:0] ST_RDSR   = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;
  function automatic logic [2:0] decode_op(input logic [7:0] op);
    return op == OP_READ ? ST_ADDR : op == OP_RDID ? ST_RDID : op == OP_RDSR ? ST_RDSR : ST_IGNORE;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus one history stage giving rise/fall pulses (clk, rst, d in; rise, fall out)
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target for READ/RDID/RDSR/WREN/WRDI (SPI_* pins, MEM_* byte read port, CLK/RST)
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SPI_CSN,
  input  logic                  SPI_CLK,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  SPI_MISO_OE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_RE,
  input  logic [7:0]            MEM_RDATA
);
  logic [2:0] csn_q, csn_d;
  logic [1:0] mosi_q, mosi_d;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s, oe;
  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [22:0] rx_q, rx_d;
  logic [23:0] rx_in;
  logic [7:0] tx_q, tx_d, sh_q, sh_d, id_byte, src;
  logic [1:0] idx_q, idx_d;
  logic miso_q, miso_d, wel_q, wel_d, re_q, re_d, ld_q, ld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  spi_sync_edge u_sclk (.clk(CLK), .rst(RST), .d(SPI_CLK), .rise(sclk_rise), .fall(sclk_fall));
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign mosi_s = mosi_q[1];
  assign rx_in = {rx_q, mosi_s};
  assign oe = state_q == ST_READ || state_q == ST_RDID || state_q == ST_RDSR;
  assign id_byte = idx_q == 2'd0 ? JEDEC_ID[23:16] : idx_q == 2'd1 ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
  assign src = state_q == ST_READ ? tx_q : state_q == ST_RDID ? id_byte : {6'b0, wel_q, 1'b0};
  always_comb begin
    csn_d = {csn_q[1:0], SPI_CSN};
    mosi_d = {mosi_q[0], SPI_MOSI};
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = ld_q ? MEM_RDATA : tx_q;
    sh_d = sh_q;
    idx_d = idx_q;
    miso_d = miso_q;
    wel_d = wel_q;
    re_d = 1'b0;
    ld_d = re_q;
    addr_d = addr_q;
    if (state_q == ST_IDLE) begin
      if (csn_fall) begin
        state_d = ST_CMD;
        cnt_d = '0;
        rx_d = '0;
      end
    end else if (csn_rise) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      rx_d = '0;
      sh_d = '0;
      miso_d = 1'b0;
    end else if (sclk_rise && (state_q == ST_CMD || state_q == ST_ADDR)) begin
      rx_d = rx_in[22:0];
      cnt_d = cnt_q + 5'd1;
      if (state_q == ST_CMD && cnt_q == 5'd7) begin
        state_d = decode_op(rx_in[7:0]);
        cnt_d = '0;
        idx_d = '0;
        wel_d = rx_in[7:0] == OP_WREN ? 1'b1 : rx_in[7:0] == OP_WRDI ? 1'b0 : wel_q;
      end else if (state_q == ST_ADDR && cnt_q == 5'd23) begin
        state_d = ST_READ;
        cnt_d = '0;
        re_d = 1'b1;
        addr_d = rx_in[ADDR_WIDTH-1:0];
      end
    end else if (sclk_fall && oe) begin
      cnt_d = cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
      miso_d = cnt_q == 5'd0 ? src[7] : sh_q[7];
      sh_d = cnt_q == 5'd0 ? {src[6:0], 1'b0} : {sh_q[6:0], 1'b0};
      if (cnt_q == 5'd0 && state_q == ST_READ) begin
        re_d = 1'b1;
        addr_d = addr_q + 1'b1;
      end
      if (cnt_q == 5'd0 && state_q == ST_RDID) idx_d = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      csn_q <= 3'b111;
      mosi_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      miso_q <= 1'b0;
      wel_q <= 1'b0;
      re_q <= 1'b0;
      ld_q <= 1'b0;
      addr_q <= '0;
    end else begin
      csn_q <= csn_d;
      mosi_q <= mosi_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      miso_q <= miso_d;
      wel_q <= wel_d;
      re_q <= re_d;
      ld_q <= ld_d;
      addr_q <= addr_d;
    end
  assign SPI_MISO = miso_q & oe;
  assign SPI_MISO_OE = oe;
  assign MEM_ADDR = addr_q;
  assign MEM_RE = re_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: randomized self-checking bench against a byte-level flash model
module tb_spi_flash_responder;
  logic CLK = 1'b0, RST = 1'b1, SPI_CSN = 1'b1, SPI_CLK = 1'b0, SPI_MOSI = 1'b0;
  logic SPI_MISO, SPI_MISO_OE, MEM_RE;
  logic [23:0] MEM_ADDR;
  logic [7:0] MEM_RDATA = 8'h00;
  localparam logic [23:0] ID = 24'hEF4016;
  int checks = 0, errors = 0, re_cnt = 0, re_wide = 0;
  logic re_prev = 1'b0;
  logic wel = 1'b0;
  logic [23:0] addr_log[$];
  spi_flash_responder dut (
    .CLK(CLK), .RST(RST), .SPI_CSN(SPI_CSN), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE),
    .MEM_RDATA(MEM_RDATA)
  );
  always #5 CLK = ~CLK;
  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a == 24'hFFFFFF ? 8'hAA : a == 24'h000000 ? 8'h55 : 8'(a + 24'd1);
  endfunction
  always @(posedge CLK) if (MEM_RE) MEM_RDATA <= mem_f(MEM_ADDR);
  always @(negedge CLK) begin
    if (MEM_RE) begin
      addr_log.push_back(MEM_ADDR);
      re_cnt++;
      if (re_prev) re_wide++;
    end
    re_prev = MEM_RE;
  end
  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      SPI_MOSI = tx[i];
      clks(6);
      rx[i] = SPI_MISO;
      SPI_CLK = 1'b1;
      clks(6);
      SPI_CLK = 1'b0;
    end
  endtask
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    bits(tx, 8, rx);
  endtask
  task automatic cs_begin;
    SPI_CSN = 1'b0;
    clks(6);
  endtask
  task automatic cs_end;
    clks(4);
    SPI_CSN = 1'b1;
    clks(8);
  endtask
  task automatic test_reset;
    RST = 1'b1;
    clks(4);
    checks++;
    if ({SPI_MISO, SPI_MISO_OE, MEM_RE} !== 3'b000 || MEM_ADDR !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got miso/oe/re=%b%b%b addr=%h want 000 addr=000000", SPI_MISO, SPI_MISO_OE, MEM_RE, MEM_ADDR);
    end
    RST = 1'b0;
    clks(4);
    checks++;
    if (SPI_MISO_OE !== 1'b0 || MEM_RE !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got oe=%b re=%b want 0 0", SPI_MISO_OE, MEM_RE);
    end
  endtask
  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] rx;
    addr_log.delete();
    cs_begin();
    xfer(8'h03, rx);
    xfer(a[23:16], rx);
    xfer(a[15:8], rx);
    xfer(a[7:0], rx);
    checks++;
    if (SPI_MISO_OE !== 1'b1) begin
      errors++;
      $display("FAIL read_oe got %b want 1", SPI_MISO_OE);
    end
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      checks++;
      if (rx !== mem_f(a + 24'(i))) begin
        errors++;
        $display("FAIL read_byte addr=%h got %h want %h", a + 24'(i), rx, mem_f(a + 24'(i)));
      end
    end
    cs_end();
    checks++;
    if (addr_log.size() < n + 1) begin
      errors++;
      $display("FAIL read_re_count got %0d want >=%0d", addr_log.size(), n + 1);
    end else
      for (int j = 0; j <= n; j++) begin
        checks++;
        if (addr_log[j] !== a + 24'(j)) begin
          errors++;
          $display("FAIL read_mem_addr[%0d] got %h want %h", j, addr_log[j], a + 24'(j));
        end
      end
    checks++;
    if (SPI_MISO_OE !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_after_csn got %b want 0", SPI_MISO_OE);
    end
  endtask
  task automatic do_rdid(input int n);
    logic [7:0] rx, exp;
    cs_begin();
    xfer(8'h9F, rx);
    checks++;
    if (SPI_MISO_OE !== 1'b1) begin
      errors++;
      $display("FAIL rdid_oe got %b want 1", SPI_MISO_OE);
    end
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      exp = 8'(ID >> (8 * (2 - i % 3)));
      checks++;
      if (rx !== exp) begin
        errors++;
        $display("FAIL rdid_byte[%0d] got %h want %h", i, rx, exp);
      end
    end
    cs_end();
  endtask
  task automatic do_rdsr;
    logic [7:0] rx;
    cs_begin();
    xfer(8'h05, rx);
    for (int i = 0; i < 2; i++) begin
      xfer(8'($urandom), rx);
      checks++;
      if (rx !== {6'b0, wel, 1'b0}) begin
        errors++;
        $display("FAIL rdsr_byte got %h want %h", rx, {6'b0, wel, 1'b0});
      end
    end
    cs_end();
  endtask
  task automatic do_cmd(input logic [7:0] op);
    logic [7:0] rx;
    cs_begin();
    xfer(op, rx);
    if (op == 8'h06) wel = 1'b1;
    if (op == 8'h04) wel = 1'b0;
    xfer(8'($urandom), rx);
    checks++;
    if (SPI_MISO_OE !== 1'b0 || rx !== 8'h00) begin
      errors++;
      $display("FAIL cmd_%h_no_drive got oe=%b miso_byte=%h want oe=0 byte=00", op, SPI_MISO_OE, rx);
    end
    cs_end();
  endtask
  function automatic logic [7:0] rand_unknown();
    logic [7:0] op;
    do op = 8'($urandom);
    while (op == 8'h03 || op == 8'h9F || op == 8'h05 || op == 8'h06 || op == 8'h04);
    return op;
  endfunction
  task automatic test_rdid;
    do_rdid(4);
    do_rdid(1 + int'($urandom_range(5)));
  endtask
  task automatic test_read;
    do_read(24'h000010, 3);
    do_read(24'($urandom), 1 + int'($urandom_range(3)));
  endtask
  task automatic test_wrap;
    do_read(24'hFFFFFF, 2);
  endtask
  task automatic test_status;
    do_rdsr();
    do_cmd(8'h06);
    do_rdsr();
    do_cmd(8'h04);
    do_rdsr();
  endtask
  task automatic test_abort;
    logic [7:0] rx;
    int re0;
    re0 = re_cnt;
    cs_begin();
    xfer(8'h03, rx);
    xfer(8'h12, rx);
    bits(8'h34, 4, rx);
    cs_end();
    checks++;
    if (re_cnt !== re0) begin
      errors++;
      $display("FAIL abort_no_re got %0d strobes want 0", re_cnt - re0);
    end
    do_rdid(1);
    do_cmd(8'hAB);
    do_cmd(rand_unknown());
  endtask
  task automatic test_reset_mid_read;
    logic [7:0] rx;
    cs_begin();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    xfer(8'h01, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    bits(8'h00, 3, rx);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    checks++;
    if (SPI_MISO_OE !== 1'b0 || MEM_RE !== 1'b0 || SPI_MISO !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read got oe=%b re=%b miso=%b want 0 0 0", SPI_MISO_OE, MEM_RE, SPI_MISO);
    end
    SPI_CSN = 1'b1;
    clks(3);
    RST = 1'b0;
    wel = 1'b0;
    clks(6);
    do_rdid(1);
  endtask
  task automatic test_back_to_back;
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(4))
        0: do_read(24'($urandom), 1 + int'($urandom_range(2)));
        1: do_rdid(1 + int'($urandom_range(3)));
        2: do_rdsr();
        3: do_cmd($urandom_range(1) ? 8'h06 : 8'h04);
        default: do_cmd(rand_unknown());
      endcase
    end
    checks++;
    if (re_wide !== 0) begin
      errors++;
      $display("FAIL mem_re_width got %0d multi-cycle strobes want 0", re_wide);
    end
  endtask
  initial begin
    test_reset();
    test_rdid();
    test_read();
    test_wrap();
    test_status();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, width of the memory address presented on MEM_ADDR.
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4016, the three ID bytes returned MSB-first by RDID.
REQ-003 SHALL use one clock and an asynchronous active-high reset, with clock port CLK and reset port RST.
REQ-004 CLK  input  1  system clock; all logic rising-edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 SPI_CSN  input  1  chip select from flash initiator, active low, asynchronous to CLK.
REQ-007 SPI_CLK  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-008 SPI_MOSI  input  1  serial data in, MSB first.
REQ-009 SPI_MISO  output  1  serial data out, MSB first.
REQ-010 SPI_MISO_OE  output  1  MISO drive enable for the top-level tristate.
REQ-011 MEM_ADDR  output  ADDR_WIDTH  byte address of the backing read memory.
REQ-012 MEM_RE  output  1  one-cycle read strobe.
REQ-013 MEM_RDATA  input  8  read data, valid exactly 1 CLK after MEM_RE.

Function
REQ-014 SHALL pass SPI_CSN, SPI_CLK and SPI_MOSI through 2-flop synchronizers, then detect SCLK rise/fall edges with one extra register stage.
REQ-015 Operation is guaranteed only when the SPI_CLK high and low phases each last at least 4 CLK periods.
REQ-016 SHALL sample MOSI on each detected SCLK rise.
REQ-017 SHALL update MISO on each detected SCLK fall, within 4 CLK of the pin edge.
REQ-018 States SHALL be IDLE, CMD, ADDR, READ, RDID, RDSR, IGNORE.
REQ-019 IDLE -> CMD on synchronized CSN falling; bit counter cleared.
REQ-020 CMD: after 8 bits, decode as follows:
- 0x03 -> ADDR
- 0x9F -> RDID
- 0x05 -> RDSR
- 0x06 -> set WEL, go to IGNORE
- 0x04 -> clear WEL, go to IGNORE
- any other value -> IGNORE
REQ-021 ADDR: shift in 24 bits; keep the low ADDR_WIDTH bits; on the 24th rise, pulse MEM_RE with MEM_ADDR = the received address, load MEM_RDATA into the TX shift register, then go to READ.
REQ-022 READ: drive one byte per 8 SCLK falls. At the start of each byte, increment the address (wrapping from 2^ADDR_WIDTH-1 to 0) and prefetch the next byte with MEM_RE so it is loaded before the byte boundary.
REQ-023 RDID: drive the JEDEC_ID bytes [23:16], [15:8], [7:0], then repeat from [23:16] while CSN stays low.
REQ-024 RDSR: repeatedly drive the status byte {6'b0, WEL, 1'b0}.
REQ-025 SPI_MISO_OE SHALL be 1 only in READ, RDID and RDSR; SPI_MISO SHALL be 0 whenever OE is 0.
REQ-026 Synchronized CSN rising in any state SHALL return to IDLE the next CLK, with OE = 0 and any partial byte discarded.
REQ-027 WEL SHALL change only on completion of the full 8-bit command; it persists across transactions.
REQ-028 MEM_RE SHALL be at most one cycle wide per byte and never asserted outside ADDR/READ.
REQ-029 CSN rising in the same CLK as an SCLK edge: the CSN return to IDLE takes priority and the edge is ignored.

Reset
REQ-030 RST asserted SHALL asynchronously force:
- state IDLE
- WEL 0
- all shift registers and counters 0
- SPI_MISO 0, SPI_MISO_OE 0
- MEM_RE 0, MEM_ADDR 0
- synchronizer flops to CSN=1, SCLK=0
REQ-031 Reset asserted mid-transaction SHALL abort it; after release the block waits for a fresh CSN fall.

Structure
REQ-032 Command opcodes (0x03, 0x9F, 0x05, 0x06, 0x04) and the state encoding SHALL live in a shared package spi_flash_pkg.
REQ-033 One sub-module, spi_sync_edge (2-flop synchronizer plus rise/fall pulse), SHALL be instantiated once for SCLK; CSN and MOSI SHALL use plain synchronizers.

Verification
REQ-034 RDID: CSN low, send 0x9F, clock 32 bits -> MISO bytes EF, 40, 16, EF; OE=1 after the command.
REQ-035 READ: memory preloaded with byte i = i+1 (mod 256), send 03 00 00 10 plus 3 bytes -> MISO 11, 12, 13 and MEM_ADDR sequence 0x10, 0x11, 0x12, 0x13.
REQ-036 Wrap: READ at address 0xFFFFFF, with 0xFFFFFF = 0xAA and 0x000000 = 0x55 -> MISO AA then 55.
REQ-037 Status: RDSR -> 0x00; WREN; RDSR -> 0x02; WRDI; RDSR -> 0x00.
REQ-038 Abort: raise CSN after 12 address bits, then send 0x9F -> EF returned, no MEM_RE seen; unknown opcode 0xAB -> OE stays 0.
REQ-039 Reset mid-READ: assert RST during byte 2 -> OE = 0 and MEM_RE = 0 immediately; after release, RDID returns EF.
